// File: rtl/uart_slave_rx_engine.sv
// uart_slave_rx_engine: UART receive path with rx synchroniser, baud timing, frame FSM, error pulses and show-ahead FIFO.
// Define UART_SLAVE_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre.
module uart_slave_rx_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                          pclk,
  input  logic                          areset,
  input  logic [15:0]                   baud_div,
  input  logic                          rx,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          parity_err,
  output logic                          framing_err,
  output logic                          overrun_err,
  output logic                          busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(OVERSAMPLE);
  localparam int BIT_PT = OVERSAMPLE - 1;
`ifdef UART_SLAVE_RX_MAJORITY_EN
  localparam int START_PT = OVERSAMPLE / 2;
`else
  localparam int START_PT = OVERSAMPLE / 2 - 1;
`endif
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic [2:0] sync;
  logic rx_s, rx_q;
  logic [15:0] baud_cnt, div_m1;
  logic tick;
  state_t state;
  logic [OW-1:0] os_cnt, pt;
  logic [3:0] bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic perr, ferr, at_pt, bit_v, pop, full, last_stop, good, push;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  assign rx_s = sync[1];
  assign rx_q = sync[2];
  always_ff @(posedge pclk or posedge areset)
    if (areset) sync <= '1;
    else sync <= {sync[1:0], rx};
  assign div_m1 = (baud_div == 16'd0) ? 16'd0 : baud_div - 16'd1;
  assign tick = baud_cnt >= div_m1;
  always_ff @(posedge pclk or posedge areset)
    if (areset) baud_cnt <= '0;
    else baud_cnt <= tick ? '0 : baud_cnt + 16'd1;
  assign pt = (state == START) ? OW'(START_PT) : OW'(BIT_PT);
  assign at_pt = tick && os_cnt == pt;
`ifdef UART_SLAVE_RX_MAJORITY_EN
  logic [1:0] samp;
  // the two samples preceding the decision tick; the third is rx_s itself
  always_ff @(posedge pclk or posedge areset)
    if (areset) samp <= '1;
    else if (tick && (os_cnt == pt - OW'(2) || os_cnt == pt - OW'(1))) samp <= {samp[0], rx_s};
  assign bit_v = (samp[1] & samp[0]) | (samp[1] & rx_s) | (samp[0] & rx_s);
`else
  assign bit_v = rx_s;
`endif
  assign pop = rd_en && rd_valid;
  assign full = fifo_count == CW'(FIFO_DEPTH);
  assign last_stop = state == STOP && at_pt && bit_cnt == 4'(STOP_BITS - 1);
  assign good = last_stop && !perr && !ferr && bit_v;
  assign push = good && (!full || pop);
  always_ff @(posedge pclk or posedge areset)
    if (areset) begin
      state <= IDLE;
      os_cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      perr <= 1'b0;
      ferr <= 1'b0;
      parity_err <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
      if (tick) os_cnt <= at_pt ? '0 : os_cnt + OW'(1);
      case (state)
        IDLE: begin
          os_cnt <= '0;
          bit_cnt <= '0;
          perr <= 1'b0;
          ferr <= 1'b0;
          if (rx_q && !rx_s) state <= START;
        end
        START: if (at_pt) state <= bit_v ? IDLE : DATA;
        DATA: if (at_pt) begin
          shreg <= {bit_v, shreg[DATA_WIDTH-1:1]};
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'(DATA_WIDTH - 1)) begin
            bit_cnt <= '0;
            state <= (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: if (at_pt) begin
          perr <= ^shreg ^ bit_v ^ (PARITY_ODD != 0);
          state <= STOP;
        end
        STOP: if (at_pt) begin
          ferr <= ferr | !bit_v;
          bit_cnt <= bit_cnt + 4'd1;
          if (last_stop) begin
            state <= IDLE;
            parity_err <= perr;
            framing_err <= ferr | !bit_v;
            overrun_err <= good && !push;
          end
        end
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge pclk)
    if (push) mem[wptr] <= shreg;
  always_ff @(posedge pclk or posedge areset)
    if (areset) begin
      wptr <= '0;
      rptr <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  assign rd_valid = fifo_count != '0;
  assign rd_data = rd_valid ? mem[rptr] : '0;
  assign busy = state != IDLE;
endmodule
